logic_l1_frame_pack: RTL and testbench
======================================

// Module: logic_l1_frame_pack
// PURPOSE
//  Downstream stage of the logic_l1 datapath: samples the free-running ovG_data word stream,
//  groups words into fixed-length frames, appends a per-frame XOR checksum to the last word,
//  and buffers the result in a small FIFO. Output side uses a valid/ready handshake so a
//  stalling consumer does not have to keep pace with the logic_l1 output rate.
// PARAMETERS
//  PAR_DATA_BITS   8  width of data word (matches upstream logic_l1 PAR_DATA_BITS)
//  PAR_FRAME_LEN   4  words per frame, >=2
//  PAR_FIFO_DEPTH  4  FIFO entries, power of 2, >=2
// PORTS
//  ib_clk       in   1                    single clock, all logic rising-edge
//  ib_rst_n     in   1                    reset, asynchronous, active-low
//  ib_en        in   1                    1 = ivG_data is a valid sample this cycle
//  ivG_data     in   PAR_DATA_BITS        data word from logic_l1 ovG_data
//  ib_ovf_clr   in   1                    synchronous clear of sticky ob_ovf
//  ovG_data     out  PAR_DATA_BITS        FIFO head data word
//  ovG_csum     out  PAR_DATA_BITS        frame checksum; meaningful only when ob_last=1, else 0
//  ob_last      out  1                    head word is last word of its frame
//  ob_valid     out  1                    head entry valid (FIFO not empty)
//  ib_ready     in   1                    consumer accepts head when ob_valid & ib_ready
//  ob_ovf       out  1                    sticky: at least one sample dropped on full FIFO
//  ovG_level    out  $clog2(PAR_FIFO_DEPTH+1)  current FIFO occupancy
// BEHAVIOUR
//  Reset (ib_rst_n=0, async assert, sync deassert via the flops): FIFO empty, ovG_level=0,
//   ob_valid=0, ob_last=0, ovG_data=0, ovG_csum=0, ob_ovf=0, word index=0, checksum acc=0.
//   Reset mid-frame discards the partial frame; the next accepted word is word 0 of a new frame.
//  Push: push = ib_en & (~full | pop). Pop: pop = ob_valid & ib_ready.
//   Full FIFO with simultaneous pop accepts the push; level unchanged.
//   Empty FIFO: push only, no same-cycle bypass; word visible on ovG_data next cycle.
//  Latency: sample accepted at edge N -> ob_valid=1 with that word after edge N (1 cycle).
//  Framing: index counter 0..PAR_FRAME_LEN-1 increments on each accepted push, wraps to 0.
//   Accepted word with index=PAR_FRAME_LEN-1 is stored with last=1 and
//   csum = acc ^ ivG_data; acc then clears to 0. Other words: acc <= acc ^ ivG_data, csum=0.
//   Index=0 word: acc <= ivG_data (fresh start, no stale bits).
//  Drop: ib_en & full & ~pop -> word discarded, index/acc NOT advanced, ob_ovf <= 1.
//   ob_ovf stays 1 until ib_ovf_clr=1; clear and a new drop in the same cycle -> ob_ovf=1 (set wins).
//  FIFO: pointers log2(PAR_FIFO_DEPTH) bits, natural wrap; entry = {last, csum, data}.
//   Outputs ovG_data/ovG_csum/ob_last driven from head entry; hold stable while ob_valid & ~ib_ready.
//   When empty, ovG_data/ovG_csum/ob_last drive 0.
//  ib_ready ignored when ob_valid=0; ib_en ignored during reset.
// TESTING
//  1. Reset, ib_ready=1, ib_en=1, data 0x01,0x02,0x04,0x08 -> out 1 cycle later, ob_last on 4th, ovG_csum=0x0F.
//  2. ib_ready=0, push 5 words (DEPTH=4) -> level=4, 5th dropped, ob_ovf=1; drain -> words 1..4, frame counter at 0.
//  3. Full FIFO, ib_en=1 & ib_ready=1 same cycle -> push accepted, level stays 4, no ovf.
//  4. ob_ovf=1, ib_ovf_clr=1 with drop same cycle -> ob_ovf stays 1; next cycle clr only -> 0.
//  5. Push 2 words of a frame, assert ib_rst_n=0 mid-cycle -> outputs 0 immediately; after release
//     push 0xAA,0x55,0xFF,0x00 -> ob_last on 4th, ovG_csum=0x00.
//  6. Random ib_en/ib_ready 10k cycles vs reference model -> data order, last, csum, level, ovf match.

Source files
------------

// File: rtl/logic_l1_frame_pack.sv
// rtl/logic_l1_frame_pack.sv - frames the logic_l1 word stream, appends XOR checksum, buffers in a FIFO
module logic_l1_frame_pack #(
    parameter int PAR_DATA_BITS  = 8,
    parameter int PAR_FRAME_LEN  = 4,
    parameter int PAR_FIFO_DEPTH = 4
) (
    input  logic                                    ib_clk,
    input  logic                                    ib_rst_n,
    input  logic                                    ib_en,
    input  logic [PAR_DATA_BITS-1:0]                ivG_data,
    input  logic                                    ib_ovf_clr,
    output logic [PAR_DATA_BITS-1:0]                ovG_data,
    output logic [PAR_DATA_BITS-1:0]                ovG_csum,
    output logic                                    ob_last,
    output logic                                    ob_valid,
    input  logic                                    ib_ready,
    output logic                                    ob_ovf,
    output logic [$clog2(PAR_FIFO_DEPTH+1)-1:0]     ovG_level
);

    localparam int LVW = $clog2(PAR_FIFO_DEPTH + 1);
    localparam int PTW = $clog2(PAR_FIFO_DEPTH);
    localparam int IDW = (PAR_FRAME_LEN > 1) ? $clog2(PAR_FRAME_LEN) : 1;
    localparam int EW  = 2 * PAR_DATA_BITS + 1;

    localparam logic [IDW-1:0] LAST_IDX   = IDW'(PAR_FRAME_LEN - 1);
    localparam logic [LVW-1:0] FULL_LEVEL = LVW'(PAR_FIFO_DEPTH);

    // FIFO storage; entry layout is {last, csum, data}
    logic [EW-1:0]            mem_q [PAR_FIFO_DEPTH];

    logic [PTW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LVW-1:0]           level_q,  level_d;
    logic [IDW-1:0]           idx_q,    idx_d;
    logic [PAR_DATA_BITS-1:0] acc_q,    acc_d;
    logic                     ovf_q,    ovf_d;

    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     drop;
    logic                     is_last;
    logic [PAR_DATA_BITS-1:0] csum_in;
    logic [EW-1:0]            entry_in;
    logic [EW-1:0]            head;

    // Handshake decode, framing arithmetic and next-state for pointers, level, framer and ovf flag
    always_comb begin
        full     = (level_q == FULL_LEVEL);
        empty    = (level_q == '0);
        pop      = ~empty & ib_ready;
        push     = ib_en & (~full | pop);
        drop     = ib_en & full & ~pop;

        is_last  = (idx_q == LAST_IDX);
        csum_in  = is_last ? (acc_q ^ ivG_data) : '0;
        entry_in = {is_last, csum_in, ivG_data};

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (is_last) begin
                idx_d = '0;
                acc_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
                // word 0 seeds the accumulator so nothing from a discarded frame leaks in
                acc_d = (idx_q == '0) ? ivG_data : (acc_q ^ ivG_data);
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // a new drop outranks a clear in the same cycle
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ib_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge ib_clk or negedge ib_rst_n) begin
        if (!ib_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry write; contents need no reset because outputs are masked while empty
    always_ff @(posedge ib_clk) begin
        if (ib_rst_n && push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    // Head entry drives the outputs, forced to zero while the FIFO is empty
    always_comb begin
        head      = mem_q[rd_ptr_q];
        ob_valid  = ~empty;
        ovG_level = level_q;
        ob_ovf    = ovf_q;
        ovG_data  = empty ? '0   : head[PAR_DATA_BITS-1:0];
        ovG_csum  = empty ? '0   : head[2*PAR_DATA_BITS-1:PAR_DATA_BITS];
        ob_last   = empty ? 1'b0 : head[EW-1];
    end

endmodule

// File: tb/tb_logic_l1_frame_pack.sv
// tb/tb_logic_l1_frame_pack.sv - scoreboard bench for logic_l1_frame_pack
module tb_logic_l1_frame_pack;

    localparam int DW    = 8;
    localparam int FLEN  = 4;
    localparam int DEPTH = 4;
    localparam int LVW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [DW-1:0]  din = '0;
    logic           ovf_clr = 1'b0;
    logic           ready = 1'b0;
    logic [DW-1:0]  dout;
    logic [DW-1:0]  csum;
    logic           last;
    logic           valid;
    logic           ovf;
    logic [LVW-1:0] level;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard entries: {last, csum, data}
    logic [2*DW:0]  exp_q[$];
    int             m_idx;
    logic [DW-1:0]  m_acc;
    logic           m_ovf;

    always #5 clk = ~clk;

    logic_l1_frame_pack #(
        .PAR_DATA_BITS (DW),
        .PAR_FRAME_LEN (FLEN),
        .PAR_FIFO_DEPTH(DEPTH)
    ) dut (
        .ib_clk    (clk),
        .ib_rst_n  (rst_n),
        .ib_en     (en),
        .ivG_data  (din),
        .ib_ovf_clr(ovf_clr),
        .ovG_data  (dout),
        .ovG_csum  (csum),
        .ob_last   (last),
        .ob_valid  (valid),
        .ib_ready  (ready),
        .ob_ovf    (ovf),
        .ovG_level (level)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_idx = 0;
        m_acc = '0;
        m_ovf = 1'b0;
    endtask

    // Compare outputs against the model, drive one cycle of inputs, advance the model, wait a cycle.
    // Called at a falling edge.
    task automatic cycle(input logic e, input logic [DW-1:0] d, input logic r, input logic c);
        logic           p_pop, p_push, p_full, p_last;
        logic [DW-1:0]  p_csum;
        logic [2*DW:0]  hd;
        check_value("valid", 32'(valid), 32'(exp_q.size() != 0));
        check_value("level", 32'(level), 32'(exp_q.size()));
        check_value("ovf",   32'(ovf),   32'(m_ovf));
        hd = (exp_q.size() != 0) ? exp_q[0] : '0;
        check_value("data",  32'(dout), 32'(hd[DW-1:0]));
        check_value("csum",  32'(csum), 32'(hd[2*DW-1:DW]));
        check_value("last",  32'(last), 32'(hd[2*DW]));

        en = e; din = d; ready = r; ovf_clr = c;

        p_full = (exp_q.size() == DEPTH);
        p_pop  = (exp_q.size() != 0) && r;
        p_push = e && (!p_full || p_pop);
        if (p_pop) void'(exp_q.pop_front());
        if (p_push) begin
            p_last = (m_idx == FLEN - 1);
            p_csum = p_last ? (m_acc ^ d) : '0;
            exp_q.push_back({p_last, p_csum, d});
            if (p_last) begin
                m_idx = 0;
                m_acc = '0;
            end else begin
                m_acc = (m_idx == 0) ? d : (m_acc ^ d);
                m_idx++;
            end
        end
        if (e && p_full && !p_pop) m_ovf = 1'b1;
        else if (c)                m_ovf = 1'b0;
        @(negedge clk);
    endtask

    // Assert reset between clock edges, check outputs clear at once, release on a later falling edge
    task automatic do_reset();
        en = 1'b0; ovf_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        check_value("rst_valid", 32'(valid), 32'd0);
        check_value("rst_level", 32'(level), 32'd0);
        check_value("rst_data",  32'(dout),  32'd0);
        check_value("rst_csum",  32'(csum),  32'd0);
        check_value("rst_last",  32'(last),  32'd0);
        check_value("rst_ovf",   32'(ovf),   32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: streaming frame 01,02,04,08 with a ready consumer
        cycle(1, 8'h01, 1, 0);
        check_value("t1_first_data", 32'(dout), 32'h01);
        cycle(1, 8'h02, 1, 0);
        cycle(1, 8'h04, 1, 0);
        cycle(1, 8'h08, 1, 0);
        check_value("t1_last",  32'(last), 32'd1);
        check_value("t1_csum",  32'(csum), 32'h0F);
        check_value("t1_data",  32'(dout), 32'h08);
        cycle(0, 8'h00, 1, 0);

        // 2: five pushes into a stalled FIFO, fifth dropped, then drain
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h11 + i), 0, 0);
        check_value("t2_level", 32'(level), 32'd4);
        check_value("t2_ovf",   32'(ovf),   32'd1);
        for (int i = 0; i < 4; i++) begin
            check_value("t2_drain", 32'(dout), 32'(8'h11 + i));
            if (i == 3) begin
                check_value("t2_last", 32'(last), 32'd1);
                check_value("t2_csum", 32'(csum), 32'h04);
            end
            cycle(0, 8'h00, 1, 0);
        end
        cycle(0, 8'h00, 1, 1);
        check_value("t2_ovf_clr", 32'(ovf), 32'd0);

        // 3: push and pop together on a full FIFO
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h21 + i), 0, 0);
        check_value("t3_full", 32'(level), 32'd4);
        cycle(1, 8'h25, 1, 0);
        check_value("t3_level", 32'(level), 32'd4);
        check_value("t3_ovf",   32'(ovf),   32'd0);
        check_value("t3_head",  32'(dout),  32'h22);

        // 4: clear collides with a drop, then clear alone
        cycle(1, 8'h26, 0, 0);
        check_value("t4_ovf_set", 32'(ovf), 32'd1);
        cycle(1, 8'h27, 0, 1);
        check_value("t4_set_wins", 32'(ovf), 32'd1);
        cycle(0, 8'h00, 0, 1);
        check_value("t4_cleared", 32'(ovf), 32'd0);
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0);

        // 5: reset mid-frame, then a fresh frame AA,55,FF,00
        cycle(1, 8'h31, 0, 0);
        cycle(1, 8'h32, 0, 0);
        do_reset();
        cycle(1, 8'hAA, 1, 0);
        cycle(1, 8'h55, 1, 0);
        cycle(1, 8'hFF, 1, 0);
        cycle(1, 8'h00, 1, 0);
        check_value("t5_last", 32'(last), 32'd1);
        check_value("t5_csum", 32'(csum), 32'h00);
        cycle(0, 8'h00, 1, 0);

        // 6: random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            cycle(logic'($urandom_range(0, 99) < 70), 8'($urandom),
                  logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 5));
        end
        for (int i = 0; i < 6; i++) cycle(0, 8'h00, 1, 0);
        check_value("final_empty", 32'(valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
